ram_fill_check_ctrl: RTL and testbench
======================================

Name: ram_fill_check_ctrl

Overview:
Synchronous sequencer that drives the 128x16 asynchronous RAM (ram128x16) from the clocked system side.
- On a start pulse it writes a selected data pattern to every address, then reads every address back and compares against the expected value.
- Reports done, pass, error count and first failing address.
- Replaces hand-timed strobe sequencing with a clocked master feeding the RAM's adrs/dataIn/_ce/_we/_oe pins.

Parameters:
ADDR_W, 7, RAM address width
DATA_W, 16, RAM data width
DEPTH, 128, number of words exercised (addresses 0..DEPTH-1, DEPTH <= 2**ADDR_W)
READ_WAIT, 1, cycles _oe held low before dataOut is sampled (>=1)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
start  input  1  single-cycle request; sampled only in IDLE
mode  input  2  pattern: 0 all-zero, 1 all-ones, 2 checkerboard, 3 address-echo; latched on start
adrs  output  ADDR_W  RAM address
data_wr  output  DATA_W  write data to RAM dataIn (bench/top tri-states it with drive_en)
drive_en  output  1  1 = controller drives the dataIn bus
_ce  output  1  RAM chip enable, active low
_we  output  1  RAM write enable, active low
_oe  output  1  RAM output enable, active low
data_rd  input  DATA_W  RAM dataOut
busy  output  1  high from the cycle after start until done
done  output  1  one-cycle pulse at end of check
pass  output  1  1 when last run had zero mismatches; held until next start
err_count  output  ADDR_W+1  mismatch count of last run, saturating
fail_addr  output  ADDR_W  address of first mismatch; 0 if none

Behaviour:
- Reset (async, immediate): state IDLE; _ce=_we=_oe=1; drive_en=0; adrs=0; data_wr=0; busy=0; done=0; pass=0; err_count=0; fail_addr=0. A reset mid-write deasserts _we in the same instant; no partial-cycle strobes afterwards.
- All outputs are registered; no combinational path from inputs to RAM pins.
- Pattern: 0 -> 16'h0000; 1 -> 16'hFFFF; 2 -> adrs[0] ? 16'hAAAA : 16'h5555; 3 -> zero-extended adrs.
- FSM states: IDLE, W_SETUP, W_PULSE, W_HOLD, R_WAIT, R_SAMPLE, DONE.
- IDLE: strobes high, drive_en=0. start=1 -> latch mode, adrs=0, clear err_count/fail_addr/pass, busy=1, go W_SETUP.
- W_SETUP (1 cycle): _ce=0, _we=1, _oe=1, drive_en=1, data_wr=pattern(adrs).
- W_PULSE (1 cycle): _we=0; adrs, data_wr, drive_en unchanged.
- W_HOLD (1 cycle): _we=1, data still driven. If adrs==DEPTH-1 -> adrs=0, go R_WAIT; else adrs+1, go W_SETUP.
- adrs and data_wr must be stable across W_SETUP..W_HOLD; _we never low while drive_en=0 or _ce=1.
- R_WAIT (READ_WAIT cycles): _ce=0, _oe=0, _we=1, drive_en=0. drive_en drops in the same cycle _oe falls; never both driving.
- R_SAMPLE (1 cycle): compare data_rd with pattern(adrs). On mismatch, err_count+1, saturating at all-ones; if it was the first mismatch, fail_addr=adrs. If adrs==DEPTH-1 -> go DONE; else adrs+1, go R_WAIT.
- DONE (1 cycle): strobes high, done=1, busy=0, pass=(err_count==0); next state IDLE.
- Latency: start sampled at edge 0 -> done high in cycle 3*DEPTH + (READ_WAIT+1)*DEPTH + 1 = 641 with defaults.
- start while busy or in DONE is ignored; mode changes while busy are ignored.
- Address wraps only via the explicit DEPTH-1 checks; counter never runs past DEPTH-1.

Decomposition:
- Package ram_ctrl_pkg: state enum, mode codes (MODE_ZERO/ONES/CHECKER/ADDR), constants CHECKER_A=16'hAAAA and CHECKER_B=16'h5555.
- One combinational sub-module, ram_pattern_gen (mode, adrs -> expected data). It is shared by the write path and the compare path so both use identical expected values.
- FSM, address counter, wait counter and result registers stay in the top module.

Test Plan:
- mode=0, behavioural ram128x16 attached, start pulse -> 128 writes of 0000 then 128 reads; done at cycle 641, pass=1, err_count=0, fail_addr=0.
- mode=3 -> RAM word 0x2A holds 0x002A after the write phase; pass=1.
- mode=2, bench forces data_rd bit 0 flipped at adrs 0x2A and 0x50 -> err_count=2, fail_addr=0x2A, pass=0.
- Protocol checker on every cycle: _we=0 implies _ce=0 and drive_en=1; never drive_en=1 with _oe=0; adrs/data_wr constant while _we=0.
- start asserted again at cycle 100 of a run -> ignored; done still at cycle 641 and exactly one done pulse.
- rst raised during W_PULSE of address 10 -> _we, _ce and _oe go high immediately, busy=0; a fresh start afterwards completes with pass=1.

Source files
------------

// File: rtl/ram_ctrl_pkg.sv
// Shared constants for the ram128x16 fill/check sequencer: FSM state codes, pattern modes and
// checkerboard words.
package ram_ctrl_pkg;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_W_SETUP  = 3'd1;
    localparam logic [2:0] ST_W_PULSE  = 3'd2;
    localparam logic [2:0] ST_W_HOLD   = 3'd3;
    localparam logic [2:0] ST_R_WAIT   = 3'd4;
    localparam logic [2:0] ST_R_SAMPLE = 3'd5;
    localparam logic [2:0] ST_DONE     = 3'd6;

    localparam logic [1:0] MODE_ZERO    = 2'd0;
    localparam logic [1:0] MODE_ONES    = 2'd1;
    localparam logic [1:0] MODE_CHECKER = 2'd2;
    localparam logic [1:0] MODE_ADDR    = 2'd3;

    localparam logic [15:0] CHECKER_A = 16'hAAAA;
    localparam logic [15:0] CHECKER_B = 16'h5555;

endpackage

// File: rtl/ram_pattern_gen.sv
// Expected RAM word for a given pattern mode and address; feeds both the write data and the
// read-back compare so the two can never disagree.
module ram_pattern_gen
    import ram_ctrl_pkg::*;
#(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 16
) (
    input  logic [1:0]        i_mode,
    input  logic [ADDR_W-1:0] i_adrs,
    output logic [DATA_W-1:0] o_data
);

    always_comb begin
        unique case (i_mode)
            MODE_ZERO:    o_data = '0;
            MODE_ONES:    o_data = '1;
            MODE_CHECKER: o_data = i_adrs[0] ? DATA_W'(CHECKER_A) : DATA_W'(CHECKER_B);
            MODE_ADDR:    o_data = DATA_W'(i_adrs);
            default:      o_data = '0;
        endcase
    end

endmodule

// File: rtl/ram_fill_check_ctrl.sv
// Clocked master for the asynchronous ram128x16: fills every word with a pattern, reads it all
// back, and reports pass / mismatch count / first failing address. All pins are registered.
module ram_fill_check_ctrl
    import ram_ctrl_pkg::*;
#(
    parameter int ADDR_W    = 7,
    parameter int DATA_W    = 16,
    parameter int DEPTH     = 128,
    parameter int READ_WAIT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [1:0]        mode,
    output logic [ADDR_W-1:0] adrs,
    output logic [DATA_W-1:0] data_wr,
    output logic              drive_en,
    output logic              _ce,
    output logic              _we,
    output logic              _oe,
    input  logic [DATA_W-1:0] data_rd,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [ADDR_W:0]   err_count,
    output logic [ADDR_W-1:0] fail_addr
);

    localparam logic [ADDR_W-1:0] LAST_ADRS = ADDR_W'(DEPTH - 1);
    localparam int                WAIT_W    = (READ_WAIT > 1) ? $clog2(READ_WAIT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(READ_WAIT - 1);

    logic [2:0]        r_state, w_state_d;
    logic [1:0]        r_mode, w_mode_d;
    logic [ADDR_W-1:0] r_adrs, w_adrs_d;
    logic [WAIT_W-1:0] r_wait, w_wait_d;
    logic [ADDR_W:0]   r_err, w_err_d;
    logic [ADDR_W-1:0] r_fail, w_fail_d;
    logic              r_pass, w_pass_d;
    logic [DATA_W-1:0] r_data;
    logic              r_ce, r_we, r_oe, r_drive, r_busy, r_done;
    logic [DATA_W-1:0] w_pattern;
    logic              w_write, w_read;

    // Generator looks at the next address/mode so data_wr is valid on the first W_SETUP cycle
    // and r_data already holds the expected word when R_SAMPLE compares.
    ram_pattern_gen #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_pattern (
        .i_mode (w_mode_d),
        .i_adrs (w_adrs_d),
        .o_data (w_pattern)
    );

    always_comb begin
        w_state_d = r_state;
        w_mode_d  = r_mode;
        w_adrs_d  = r_adrs;
        w_wait_d  = r_wait;
        w_err_d   = r_err;
        w_fail_d  = r_fail;
        w_pass_d  = r_pass;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_d = ST_W_SETUP;
                    w_mode_d  = mode;
                    w_adrs_d  = '0;
                    w_err_d   = '0;
                    w_fail_d  = '0;
                    w_pass_d  = 1'b0;
                end
            end
            ST_W_SETUP: w_state_d = ST_W_PULSE;
            ST_W_PULSE: w_state_d = ST_W_HOLD;
            ST_W_HOLD: begin
                w_wait_d = '0;
                if (r_adrs == LAST_ADRS) begin
                    w_adrs_d  = '0;
                    w_state_d = ST_R_WAIT;
                end else begin
                    w_adrs_d  = r_adrs + 1'b1;
                    w_state_d = ST_W_SETUP;
                end
            end
            ST_R_WAIT: begin
                if (r_wait == WAIT_LAST) begin
                    w_state_d = ST_R_SAMPLE;
                end else begin
                    w_wait_d = r_wait + 1'b1;
                end
            end
            ST_R_SAMPLE: begin
                if (data_rd != r_data) begin
                    if (r_err == '0) begin
                        w_fail_d = r_adrs;
                    end
                    if (r_err != '1) begin
                        w_err_d = r_err + 1'b1;
                    end
                end
                if (r_adrs == LAST_ADRS) begin
                    w_state_d = ST_DONE;
                    w_pass_d  = (w_err_d == '0);
                end else begin
                    w_adrs_d  = r_adrs + 1'b1;
                    w_wait_d  = '0;
                    w_state_d = ST_R_WAIT;
                end
            end
            ST_DONE: w_state_d = ST_IDLE;
            default: w_state_d = ST_IDLE;
        endcase
    end

    assign w_write = (w_state_d == ST_W_SETUP) || (w_state_d == ST_W_PULSE) ||
                     (w_state_d == ST_W_HOLD);
    assign w_read  = (w_state_d == ST_R_WAIT) || (w_state_d == ST_R_SAMPLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_mode  <= MODE_ZERO;
            r_adrs  <= '0;
            r_wait  <= '0;
            r_err   <= '0;
            r_fail  <= '0;
            r_pass  <= 1'b0;
            r_data  <= '0;
            r_ce    <= 1'b1;
            r_we    <= 1'b1;
            r_oe    <= 1'b1;
            r_drive <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_d;
            r_mode  <= w_mode_d;
            r_adrs  <= w_adrs_d;
            r_wait  <= w_wait_d;
            r_err   <= w_err_d;
            r_fail  <= w_fail_d;
            r_pass  <= w_pass_d;
            if ((w_state_d == ST_W_SETUP) || (w_state_d == ST_R_WAIT)) begin
                r_data <= w_pattern;
            end
            r_ce    <= ~(w_write | w_read);
            r_we    <= ~(w_state_d == ST_W_PULSE);
            r_oe    <= ~w_read;
            r_drive <= w_write;
            r_busy  <= w_write | w_read;
            r_done  <= (w_state_d == ST_DONE);
        end
    end

    assign adrs      = r_adrs;
    assign data_wr   = r_data;
    assign drive_en  = r_drive;
    assign _ce       = r_ce;
    assign _we       = r_we;
    assign _oe       = r_oe;
    assign busy      = r_busy;
    assign done      = r_done;
    assign pass      = r_pass;
    assign err_count = r_err;
    assign fail_addr = r_fail;

endmodule

// File: tb/tb_ram_fill_check_ctrl.sv
// Bench for ram_fill_check_ctrl: behavioural async RAM, per-cycle timeline model of the pins,
// and directed runs covering each pattern, injected read faults, restart and mid-write reset.
module tb_ram_fill_check_ctrl;

    localparam int ADDR_W    = 7;
    localparam int DATA_W    = 16;
    localparam int DEPTH     = 128;
    localparam int READ_WAIT = 1;
    localparam int WR_CYC    = 3 * DEPTH;
    localparam int DONE_T    = 3 * DEPTH + (READ_WAIT + 1) * DEPTH + 1;

    logic              clk;
    logic              rst;
    logic              start;
    logic [1:0]        mode;
    logic [ADDR_W-1:0] adrs;
    logic [DATA_W-1:0] data_wr;
    logic              drive_en;
    logic              ce_n, we_n, oe_n;
    logic [DATA_W-1:0] data_rd;
    logic              busy, done, pass;
    logic [ADDR_W:0]   err_count;
    logic [ADDR_W-1:0] fail_addr;

    ram_fill_check_ctrl #(
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W),
        .DEPTH     (DEPTH),
        .READ_WAIT (READ_WAIT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .mode      (mode),
        .adrs      (adrs),
        .data_wr   (data_wr),
        .drive_en  (drive_en),
        ._ce       (ce_n),
        ._we       (we_n),
        ._oe       (oe_n),
        .data_rd   (data_rd),
        .busy      (busy),
        .done      (done),
        .pass      (pass),
        .err_count (err_count),
        .fail_addr (fail_addr)
    );

    logic [DATA_W-1:0] mem [DEPTH];
    logic              flip_en;
    int                n_tests = 0;
    int                n_fail  = 0;
    int                t       = 0;
    bit                tracking = 0;
    bit                arm      = 0;
    int                done_cnt = 0;
    logic [1:0]        run_mode;
    logic [ADDR_W:0]   exp_err;
    logic [ADDR_W-1:0] exp_fail;
    logic              exp_pass;

    // Read data is only meaningful with _ce and _oe low; a junk value elsewhere exposes bad timing.
    assign data_rd = (!ce_n && !oe_n) ?
                     (mem[adrs] ^ ((flip_en && (adrs == 7'h2A || adrs == 7'h50)) ?
                                   16'h0001 : 16'h0000)) : 16'hDEAD;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0d)", name, act, exp, t);
        end
    endtask

    function automatic logic [DATA_W-1:0] pat(input logic [1:0] m, input logic [ADDR_W-1:0] a);
        case (m)
            2'd0:    return 16'h0000;
            2'd1:    return 16'hFFFF;
            2'd2:    return a[0] ? 16'hAAAA : 16'h5555;
            default: return {9'b0, a};
        endcase
    endfunction

    // RAM storage and pin-level protocol rules.
    always @(negedge clk) begin
        if (!ce_n && !we_n && drive_en) mem[adrs] = data_wr;
        chk("we_needs_ce", {31'b0, ~we_n & ce_n}, 0);
        chk("we_needs_drive", {31'b0, ~we_n & ~drive_en}, 0);
        chk("bus_contention", {31'b0, drive_en & ~oe_n}, 0);
    end

    always @(posedge clk) begin
        if (arm) begin
            arm      = 0;
            tracking = 1;
            t        = 1;
            done_cnt = 0;
        end else if (tracking) begin
            t++;
        end
    end

    // Timeline model: cycle t after the start edge maps to (address, phase) by plain arithmetic.
    always @(negedge clk) begin
        int a, ph;
        logic [12:0] exp_pins;
        if (!rst) begin
            if (done) done_cnt++;
            if (tracking) begin
                if (t <= WR_CYC) begin
                    a  = (t - 1) / 3;
                    ph = (t - 1) % 3;
                    exp_pins = {7'(a), 1'b0, (ph == 1) ? 1'b0 : 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
                    chk("data_wr", {16'b0, data_wr}, {16'b0, pat(run_mode, 7'(a))});
                end else if (t < DONE_T) begin
                    a = (t - WR_CYC - 1) / (READ_WAIT + 1);
                    exp_pins = {7'(a), 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
                end else begin
                    exp_pins = {adrs, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
                    chk("done_results", {pass, err_count, 8'b0, fail_addr},
                        {exp_pass, exp_err, 8'b0, exp_fail});
                end
                chk("pins", {19'b0, adrs, ce_n, we_n, oe_n, drive_en, busy, done},
                    {19'b0, exp_pins});
                if (t == 1) chk("start_clears", {pass, err_count, fail_addr}, 0);
                if (t == DONE_T) tracking = 0;
            end else begin
                chk("idle_pins", {26'b0, ce_n, we_n, oe_n, drive_en, busy, done},
                    {26'b0, 6'b111000});
            end
        end
    end

    task automatic launch(input logic [1:0] m, input bit flips);
        @(negedge clk);
        mode     = m;
        flip_en  = flips;
        run_mode = m;
        exp_err  = flips ? 8'd2 : 8'd0;
        exp_fail = flips ? 7'h2A : 7'h00;
        exp_pass = !flips;
        start    = 1'b1;
        arm      = 1;
        @(posedge clk);
        #1;
        start = 1'b0;
        mode  = ~m;
    endtask

    task automatic run(input logic [1:0] m, input bit flips, input bit restart);
        int done_t;
        launch(m, flips);
        done_t = -1;
        for (int i = 0; i < DONE_T + 50; i++) begin
            @(negedge clk);
            if (restart && t == 99) start = 1'b1;
            if (restart && t == 100) start = 1'b0;
            if (done) begin
                done_t = t;
                break;
            end
        end
        chk("done_cycle", done_t, DONE_T);
        repeat (3) @(negedge clk);
        chk("done_pulses", done_cnt, 1);
        chk("result_held", {pass, err_count, 8'b0, fail_addr},
            {exp_pass, exp_err, 8'b0, exp_fail});
    endtask

    initial begin
        rst     = 1'b1;
        start   = 1'b0;
        mode    = 2'd0;
        flip_en = 1'b0;
        for (int i = 0; i < DEPTH; i++) mem[i] = 16'($urandom);
        repeat (2) @(negedge clk);
        chk("reset_pins", {adrs, ce_n, we_n, oe_n, drive_en, busy, done}, {7'h00, 6'b111000});
        chk("reset_data", {16'b0, data_wr}, 0);
        chk("reset_results", {pass, err_count, fail_addr}, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        run(2'd0, 1'b0, 1'b0);
        chk("ram_zero_7f", {16'b0, mem[127]}, 32'h0000);

        run(2'd3, 1'b0, 1'b1);
        chk("ram_addr_2a", {16'b0, mem[42]}, 32'h002A);

        run(2'd2, 1'b1, 1'b0);
        chk("ram_chk_2b", {16'b0, mem[43]}, 32'hAAAA);
        chk("err_count_lit", {24'b0, err_count}, 2);
        chk("fail_addr_lit", {25'b0, fail_addr}, 32'h2A);

        // Reset in the W_PULSE cycle of address 10 (t = 3*10 + 2).
        launch(2'd1, 1'b0);
        for (int i = 0; i < 100 && t != 32; i++) @(negedge clk);
        chk("pre_reset_we", {25'b0, adrs, we_n}, {25'b0, 7'd10, 1'b0});
        #2;
        tracking = 0;
        rst      = 1'b1;
        #1;
        chk("async_reset", {28'b0, ce_n, we_n, oe_n, busy}, {28'b0, 4'b1110});
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        run(2'd1, 1'b0, 1'b0);
        chk("ram_ones_0a", {16'b0, mem[10]}, 32'hFFFF);

        repeat (4) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
